// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BTB_STATS_EN to add the saturating update/mispredict statistics counters.
module branch_target_buffer #(
    parameter int unsigned ENTRIES   = 16,
    parameter logic [1:0]  CTR_INIT  = 2'b01,
    parameter logic [1:0]  ALLOC_CTR = 2'b10
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc,
    output logic        hit,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        inv
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispred
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       up_ctr;
    logic [31:0]      pc_plus4;
    logic             unused_pc_lo;

    assign rd_idx       = pc[IDX_W+1:2];
    assign rd_tag       = pc[31:IDX_W+2];
    assign up_idx       = upd_pc[IDX_W+1:2];
    assign up_tag       = upd_pc[31:IDX_W+2];
    assign unused_pc_lo = ^{pc[1:0], upd_pc[1:0]};

    // Zero-latency lookup straight off the registered entry state
    assign pc_plus4       = pc + 32'd4;
    assign hit            = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign predict_taken  = hit && ctr_q[rd_idx][1];
    assign predict_target = predict_taken ? target_q[rd_idx] : pc_plus4;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_ctr = ctr_q[up_idx];

    // Training: invalidate-all wins over a coincident update
    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_d[i]  = valid_q[i];
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
            ctr_d[i]    = ctr_q[i];
        end
        if (inv) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (upd_en) begin
            if (up_hit) begin
                if (upd_taken) begin
                    ctr_d[up_idx]    = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'd1;
                    target_d[up_idx] = upd_target;
                end else begin
                    ctr_d[up_idx] = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'd1;
                end
            end else if (upd_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = upd_target;
                ctr_d[up_idx]    = ALLOC_CTR;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
            end
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

`ifdef BTB_STATS_EN
    logic        accept;
    logic        up_pred_taken;
    logic        up_mispred;
    logic [31:0] stat_upd_q;
    logic [31:0] stat_upd_d;
    logic [31:0] stat_mis_q;
    logic [31:0] stat_mis_d;

    // Misprediction judged against the state the fetch stage would have seen
    assign accept        = upd_en && !inv;
    assign up_pred_taken = up_hit && up_ctr[1];
    assign up_mispred    = (up_pred_taken != upd_taken) ||
                           (up_pred_taken && upd_taken && (target_q[up_idx] != upd_target));

    always_comb begin
        stat_upd_d = stat_upd_q;
        stat_mis_d = stat_mis_q;
        if (accept && (stat_upd_q != 32'hFFFF_FFFF)) begin
            stat_upd_d = stat_upd_q + 32'd1;
        end
        if (accept && up_mispred && (stat_mis_q != 32'hFFFF_FFFF)) begin
            stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_upd_q <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_upd_q <= stat_upd_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_updates = stat_upd_q;
    assign stat_mispred = stat_mis_q;
`endif

endmodule
